// File: rtl/mainbus_pkg.sv
// Shared source indices, arbiter state encoding and a one-hot helper
// for the mainbus ownership arbiter.
package mainbus_pkg;

    localparam int SRC_ALU     = 0;
    localparam int SRC_REGBANK = 1;
    localparam int SRC_DECODER = 2;
    localparam int SRC_MEMORY  = 3;
    localparam int NUM_SRC     = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_TURN
    } arb_state_t;

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/mainbus_arbiter_rr_pick.sv
// Round-robin search: first set request strictly after ptr, wrapping,
// with ptr itself examined last.
module rr_pick
    import mainbus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mainbus_arbiter.sv
// Mainbus ownership arbiter: registered one-hot grants, round-robin fairness,
// optional hold-limit preemption and optional one-cycle idle turnaround.
module mainbus_arbiter
    import mainbus_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic               sel_alu,
    output logic               sel_register_bank,
    output logic               sel_decoder,
    output logic               sel_memory,
    output logic               bus_busy,
    output logic [1:0]         owner,
    output arb_state_t         state_dbg
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_t         state, state_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic [1:0]         owner_nxt;
    logic [1:0]         rr_ptr, rr_ptr_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [NUM_SRC-1:0] pick_req;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic               preempt;
    logic               release_bus;

    // While owned, the current owner is excluded so a handover never re-picks it.
    assign pick_req    = (state == ARB_OWNED) ? (req & ~grant) : req;
    assign preempt     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|(req & ~grant));
    assign release_bus = !req[owner] || preempt;

    rr_pick u_rr_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            owner    <= 2'd3;
            rr_ptr   <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        hold_nxt   = hold_cnt;
        case (state)
            ARB_IDLE, ARB_TURN: begin
                state_nxt = ARB_IDLE;
                if (pick_found) begin
                    state_nxt  = ARB_OWNED;
                    grant_nxt  = src_onehot(pick_idx);
                    owner_nxt  = pick_idx;
                    rr_ptr_nxt = pick_idx;
                    hold_nxt   = '0;
                end
            end
            ARB_OWNED: begin
                if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
                if (release_bus) begin
                    grant_nxt = '0;
                    hold_nxt  = '0;
                    if (TURNAROUND != 0) begin
                        state_nxt = ARB_TURN;
                    end else if (pick_found) begin
                        grant_nxt  = src_onehot(pick_idx);
                        owner_nxt  = pick_idx;
                        rr_ptr_nxt = pick_idx;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        sel_alu           = grant[SRC_ALU];
        sel_register_bank = grant[SRC_REGBANK];
        sel_decoder       = grant[SRC_DECODER];
        sel_memory        = grant[SRC_MEMORY];
        bus_busy          = |grant;
        state_dbg         = state;
    end

endmodule
